// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ctrl_pkg
//  Purpose  : Shared types and constants for the next-PC sequencer.
//             - pc_state_e  : sequencer FSM state (RST / RUN / HALT)
//             - PC_RESET_VEC: default reset fetch address
//             - PC_TRAP_VEC : default trap handler entry
//             - PC_INC      : sequential fetch increment
//             - pc_sel_t    : one-hot select code from pc_next_mux
//  Revision : 1.0  initial release
// ============================================================================
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC  = 32'h0000_0100;
  localparam logic [31:0] PC_INC       = 32'd4;

  // Bit positions inside the one-hot select code.
  localparam int SEL_INC_B    = 0;
  localparam int SEL_STALL_B  = 1;
  localparam int SEL_HALT_B   = 2;
  localparam int SEL_BRANCH_B = 3;
  localparam int SEL_JUMP_B   = 4;
  localparam int SEL_MRET_B   = 5;
  localparam int SEL_TRAP_B   = 6;
  localparam int SEL_FAULT_B  = 7;
  localparam int SEL_W        = 8;

  typedef logic [SEL_W-1:0] pc_sel_t;

  // Instruction fetch requires word alignment.
  function automatic logic is_misaligned(input logic [1:0] i_lsbs);
    return (i_lsbs != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_mux
//  Purpose  : Combinational strict-priority select of the next PC while the
//             sequencer is running. Priority: trap, mret, jump, branch,
//             halt_req, stall, sequential increment. A misaligned selected
//             jump/branch target is replaced by a fault redirect.
//  Config   : PC_CTRL_TRAP_EN - when undefined, trap/mret are ignored and a
//             misaligned target holds the PC instead of vectoring to TRAP_VEC.
//  Ports    : i_trap, i_mret, i_jump, i_branch_taken, i_halt_req, i_stall
//               request flags
//             i_jump_target, i_branch_target  redirect destinations
//             i_pc_out   current PC
//             i_epc      saved exception PC (mret destination)
//             o_pc_next  selected next PC
//             o_sel      one-hot code naming the winning source
//  Revision : 1.0  initial release
// ============================================================================
import pc_ctrl_pkg::*;

module pc_next_mux #(
  parameter logic [31:0] TRAP_VEC = PC_TRAP_VEC
) (
  input  logic        i_trap,
  input  logic        i_mret,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_halt_req,
  input  logic        i_stall,
  input  logic [31:0] i_pc_out,
  input  logic [31:0] i_epc,
  output logic [31:0] o_pc_next,
  output pc_sel_t     o_sel
);

  logic        w_trap;
  logic        w_mret;
  logic [31:0] w_fault_pc;
  logic [31:0] w_mret_pc;

`ifdef PC_CTRL_TRAP_EN
  assign w_trap     = i_trap;
  assign w_mret     = i_mret;
  assign w_fault_pc = TRAP_VEC;
  assign w_mret_pc  = i_epc;
`else
  // Without trap support the fault path freezes the PC; the core is then
  // parked in HALT by the FSM.
  logic w_unused_trap;
  assign w_unused_trap = ^{i_trap, i_mret, i_epc, TRAP_VEC};
  assign w_trap        = 1'b0;
  assign w_mret        = 1'b0;
  assign w_fault_pc    = i_pc_out;
  assign w_mret_pc     = i_pc_out;
`endif

  always_comb begin
    o_sel     = '0;
    o_pc_next = i_pc_out + PC_INC;
    if (w_trap) begin
      o_sel[SEL_TRAP_B] = 1'b1;
      o_pc_next         = TRAP_VEC;
    end else if (w_mret) begin
      o_sel[SEL_MRET_B] = 1'b1;
      o_pc_next         = w_mret_pc;
    end else if (i_jump) begin
      // A bad jump target faults; it never falls through to the branch.
      if (is_misaligned(i_jump_target[1:0])) begin
        o_sel[SEL_FAULT_B] = 1'b1;
        o_pc_next          = w_fault_pc;
      end else begin
        o_sel[SEL_JUMP_B] = 1'b1;
        o_pc_next         = i_jump_target;
      end
    end else if (i_branch_taken) begin
      if (is_misaligned(i_branch_target[1:0])) begin
        o_sel[SEL_FAULT_B] = 1'b1;
        o_pc_next          = w_fault_pc;
      end else begin
        o_sel[SEL_BRANCH_B] = 1'b1;
        o_pc_next           = i_branch_target;
      end
    end else if (i_halt_req) begin
      o_sel[SEL_HALT_B] = 1'b1;
      o_pc_next         = i_pc_out;
    end else if (i_stall) begin
      o_sel[SEL_STALL_B] = 1'b1;
      o_pc_next          = i_pc_out;
    end else begin
      o_sel[SEL_INC_B] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ctrl
//  Purpose  : Next-PC sequencer for the single-cycle core. Owns the
//             RST/RUN/HALT FSM and the epc/fault registers; the RUN-state
//             priority select lives in pc_next_mux.
//  Config   : PC_CTRL_TRAP_EN - enables trap, mret, epc and the misaligned
//             target trap redirect. Undefined: trap/mret ignored, epc = 0,
//             a misaligned target pulses fault, holds the PC and halts.
//  Ports    : clk, rst          clock, synchronous active-high reset
//             PC_out            current PC from the PC register
//             stall, halt_req, resume
//             branch_taken/branch_target, jump/jump_target, trap, mret
//             PC_next           combinational next PC
//             epc               registered exception PC
//             fault             registered one-cycle misaligned-target pulse
//             state             registered FSM state
//  Revision : 1.0  initial release
// ============================================================================
import pc_ctrl_pkg::*;

module pc_ctrl #(
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
  parameter logic [31:0] TRAP_VEC  = PC_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_out,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap,
  input  logic        mret,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] PC_next,
  output logic [31:0] epc,
  output logic        fault,
  output logic [1:0]  state
);

  pc_state_e   r_state;
  logic        r_fault;
  logic [31:0] w_mux_pc;
  pc_sel_t     w_sel;

`ifdef PC_CTRL_TRAP_EN
  logic [31:0] r_epc;
  assign epc = r_epc;
`else
  assign epc = 32'd0;
`endif

  assign fault = r_fault;
  assign state = r_state;

  // Not every select bit drives state; the rest are informational.
  logic w_unused_sel;
  assign w_unused_sel = ^w_sel;

  pc_next_mux #(
    .TRAP_VEC (TRAP_VEC)
  ) u_mux (
    .i_trap          (trap),
    .i_mret          (mret),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_halt_req      (halt_req),
    .i_stall         (stall),
    .i_pc_out        (PC_out),
    .i_epc           (epc),
    .o_pc_next       (w_mux_pc),
    .o_sel           (w_sel)
  );

  // rst forces the reset vector immediately so the PC register latches it
  // during every reset cycle.
  always_comb begin
    PC_next = RESET_VEC;
    if (!rst) begin
      case (r_state)
        ST_RUN:  PC_next = w_mux_pc;
        ST_HALT: PC_next = resume ? (PC_out + PC_INC) : PC_out;
        default: PC_next = RESET_VEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RST;
      r_fault <= 1'b0;
`ifdef PC_CTRL_TRAP_EN
      r_epc   <= 32'd0;
`endif
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        ST_RST: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_sel[SEL_HALT_B]) begin
            r_state <= ST_HALT;
          end
          if (w_sel[SEL_FAULT_B]) begin
            r_fault <= 1'b1;
`ifdef PC_CTRL_TRAP_EN
            r_epc   <= PC_out;
`else
            r_state <= ST_HALT;
`endif
          end
`ifdef PC_CTRL_TRAP_EN
          if (w_sel[SEL_TRAP_B]) begin
            r_epc <= PC_out;
          end
`endif
        end
        ST_HALT: begin
          // resume beats a concurrent halt_req.
          if (resume) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RST;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_ctrl
//  Purpose  : Self-checking bench for pc_ctrl. The bench plays the PC
//             register and keeps a behavioural model of the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PC_CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out = 32'd0;
  logic        stall = 1'b0, br = 1'b0, jmp = 1'b0, trap = 1'b0, mret = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0;
  logic [31:0] bt = 32'd0, jt = 32'd0;
  logic [31:0] pc_next, epc;
  logic        fault;
  logic [1:0]  state;

  always #5 clk = ~clk;

  pc_ctrl #(.RESET_VEC(RV), .TRAP_VEC(TV)) dut (
    .clk(clk), .rst(rst), .PC_out(pc_out), .stall(stall),
    .branch_taken(br), .branch_target(bt), .jump(jmp), .jump_target(jt),
    .trap(trap), .mret(mret), .halt_req(halt_req), .resume(resume),
    .PC_next(pc_next), .epc(epc), .fault(fault), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = reset, 1 = running, 2 = halted.
  int          m_mode = 0, n_mode;
  logic [31:0] m_epc = 32'd0, n_epc, exp_pc;
  logic        m_fault = 1'b0, n_fault;

  task automatic predict();
    logic [31:0] tgt;
    n_mode  = m_mode;
    n_epc   = m_epc;
    n_fault = 1'b0;
    exp_pc  = pc_out + 32'd4;
    if (rst) begin
      n_mode = 0; n_epc = 32'd0; exp_pc = RV;
    end else if (m_mode == 0) begin
      n_mode = 1; exp_pc = RV;
    end else if (m_mode == 2) begin
      if (resume) n_mode = 1;
      else        exp_pc = pc_out;
    end else if (TRAP_EN && trap) begin
      exp_pc = TV; n_epc = pc_out;
    end else if (TRAP_EN && mret) begin
      exp_pc = m_epc;
    end else if (jmp || br) begin
      tgt = jmp ? jt : bt;
      if (tgt % 4 != 0) begin
        n_fault = 1'b1;
        if (TRAP_EN) begin exp_pc = TV; n_epc = pc_out; end
        else begin exp_pc = pc_out; n_mode = 2; end
      end else begin
        exp_pc = tgt;
      end
    end else if (halt_req) begin
      exp_pc = pc_out; n_mode = 2;
    end else if (stall) begin
      exp_pc = pc_out;
    end
  endtask

  // Clock edge: the model commits and the bench's PC register latches.
  task automatic tick();
    @(posedge clk);
    #1;
    m_mode  = n_mode;
    m_epc   = n_epc;
    m_fault = n_fault;
    pc_out  = exp_pc;
  endtask

  task automatic idle();
    stall = 0; br = 0; jmp = 0; trap = 0; mret = 0; halt_req = 0; resume = 0;
  endtask

  task automatic test_reset();
    logic [31:0] seq [3] = '{32'h0, 32'h4, 32'h8};
    idle(); rst = 1;
    repeat (2) begin
      #1 predict();
      checks++;
      if (pc_next !== RV) begin errors++; $display("FAIL rst_pc: PC_next=%h expected %h", pc_next, RV); end
      tick();
      checks++;
      if (state !== 2'd0 || epc !== 32'd0 || fault !== 1'b0) begin
        errors++; $display("FAIL rst_regs: state=%0d epc=%h fault=%b expected 0/0/0", state, epc, fault);
      end
    end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1 predict();
      checks++;
      if (pc_next !== seq[i]) begin errors++; $display("FAIL rst_seq%0d: PC_next=%h expected %h", i, pc_next, seq[i]); end
      tick();
      checks++;
      if (state !== 2'd1) begin errors++; $display("FAIL rst_run: state=%0d expected 1", state); end
    end
  endtask

  task automatic test_branch_jump();
    idle(); pc_out = 32'h10;
    br = 1; bt = 32'h40; jmp = 1; jt = 32'h80;
    #1 predict();
    checks++;
    if (pc_next !== 32'h80) begin errors++; $display("FAIL jump_over_branch: PC_next=%h expected 00000080", pc_next); end
    tick();
    idle(); pc_out = 32'h10; br = 1; bt = 32'h40;
    #1 predict();
    checks++;
    if (pc_next !== 32'h40) begin errors++; $display("FAIL branch: PC_next=%h expected 00000040", pc_next); end
    tick();
    checks++;
    if (state !== 2'd1 || fault !== 1'b0) begin errors++; $display("FAIL branch_regs: state=%0d fault=%b expected 1/0", state, fault); end
    idle();
  endtask

  task automatic test_misaligned();
    idle(); pc_out = 32'h20; jmp = 1; jt = 32'h42;
    #1 predict();
    checks++;
    if (pc_next !== exp_pc || pc_next === 32'h42) begin
      errors++; $display("FAIL mis_pc: PC_next=%h expected %h", pc_next, exp_pc);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || epc !== m_epc || state !== m_mode[1:0]) begin
      errors++; $display("FAIL mis_regs: fault=%b epc=%h state=%0d expected 1/%h/%0d", fault, epc, state, m_epc, m_mode);
    end
    idle();
    #1 predict();
    tick();
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL mis_pulse: fault=%b expected 0", fault); end
    resume = 1;
    #1 predict();
    tick();
    idle();
  endtask

  task automatic test_trap_mret();
    idle(); pc_out = 32'h30; trap = 1;
    #1 predict();
    checks++;
    if (pc_next !== exp_pc) begin errors++; $display("FAIL trap_pc: PC_next=%h expected %h", pc_next, exp_pc); end
    tick();
    checks++;
    if (epc !== m_epc) begin errors++; $display("FAIL trap_epc: epc=%h expected %h", epc, m_epc); end
    idle(); pc_out = 32'h104; mret = 1;
    #1 predict();
    checks++;
    if (pc_next !== exp_pc) begin errors++; $display("FAIL mret_pc: PC_next=%h expected %h", pc_next, exp_pc); end
    tick();
    idle();
  endtask

  task automatic test_halt_stall();
    idle(); pc_out = 32'h8; halt_req = 1;
    #1 predict();
    checks++;
    if (pc_next !== 32'h8) begin errors++; $display("FAIL halt_enter: PC_next=%h expected 00000008", pc_next); end
    tick();
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL halt_state: state=%0d expected 2", state); end
    idle(); jmp = 1; jt = 32'h80;
    for (int i = 0; i < 5; i++) begin
      #1 predict();
      checks++;
      if (pc_next !== 32'h8) begin errors++; $display("FAIL halt_hold%0d: PC_next=%h expected 00000008", i, pc_next); end
      tick();
    end
    idle(); resume = 1; halt_req = 1;
    #1 predict();
    checks++;
    if (pc_next !== 32'hC) begin errors++; $display("FAIL resume_pc: PC_next=%h expected 0000000c", pc_next); end
    tick();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL resume_state: state=%0d expected 1", state); end
    idle(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 predict();
      checks++;
      if (pc_next !== 32'hC) begin errors++; $display("FAIL stall%0d: PC_next=%h expected 0000000c", i, pc_next); end
      tick();
    end
    idle();
  endtask

  task automatic test_wrap();
    idle(); pc_out = 32'hFFFF_FFFC;
    #1 predict();
    checks++;
    if (pc_next !== 32'h0) begin errors++; $display("FAIL wrap: PC_next=%h expected 00000000", pc_next); end
    tick();
  endtask

  task automatic test_mid_reset();
    idle(); halt_req = 1;
    #1 predict(); tick();
    idle(); rst = 1;
    #1 predict();
    checks++;
    if (pc_next !== RV) begin errors++; $display("FAIL midrst_pc: PC_next=%h expected %h", pc_next, RV); end
    tick();
    checks++;
    if (state !== 2'd0 || epc !== 32'd0 || fault !== 1'b0) begin
      errors++; $display("FAIL midrst_regs: state=%0d epc=%h fault=%b expected 0/0/0", state, epc, fault);
    end
    rst = 0;
    #1 predict();
    checks++;
    if (pc_next !== RV) begin errors++; $display("FAIL midrst_vec: PC_next=%h expected %h", pc_next, RV); end
    tick();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL midrst_run: state=%0d expected 1", state); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      trap     = ($urandom_range(0, 9) == 0);
      mret     = ($urandom_range(0, 9) == 0);
      jmp      = ($urandom_range(0, 5) == 0);
      br       = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      resume   = ($urandom_range(0, 2) == 0);
      jt = $urandom();
      bt = $urandom();
      if ($urandom_range(0, 3) != 0) jt = jt & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc_out = $urandom() & 32'hFFFF_FFFC;
      #1 predict();
      checks++;
      if (pc_next !== exp_pc) begin errors++; $display("FAIL rnd_pc%0d: PC_next=%h expected %h", i, pc_next, exp_pc); end
      tick();
      checks++;
      if (state !== m_mode[1:0] || epc !== m_epc || fault !== m_fault) begin
        errors++;
        $display("FAIL rnd_regs%0d: state=%0d epc=%h fault=%b expected %0d/%h/%b", i, state, epc, fault, m_mode, m_epc, m_fault);
      end
    end
    idle(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_branch_jump();
    test_misaligned();
    test_trap_mret();
    test_halt_stall();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_ctrl.md
# pc_ctrl

Next-PC sequencer for the single-cycle RISC-V core. Each cycle it computes `PC_next` for the `PC` register from the current `PC_out`. Redirect sources are branch, jump, trap and mret. It also handles stall and halt/resume, and keeps an exception PC and a misaligned-target fault flag. It sits between the decode/branch logic and the `PC` register, and replaces the ad-hoc `PC+4` mux in the top level.

## Interface
- `RESET_VEC`, default 32'h0000_0000: address fetched after reset.
- `TRAP_VEC`, default 32'h0000_0100: trap handler entry address.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `PC_out`  in  32  current PC, from the `PC` register.
- `stall`  in  1  hold the PC this cycle.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  JAL/JALR.
- `jump_target`  in  32  jump destination.
- `trap`  in  1  synchronous exception or ecall.
- `mret`  in  1  return from trap.
- `halt_req`  in  1  request to halt fetch.
- `resume`  in  1  leave HALT.
- `PC_next`  out  32  combinational; feeds `PC.PC_next`.
- `epc`  out  32  registered exception PC.
- `fault`  out  1  registered one-cycle pulse on a misaligned redirect target.
- `state`  out  2  registered FSM state.

## Operation
- FSM states: RST=0, RUN=1, HALT=2. Encoding 3 is unused and recovers to RST.
- RST: entered whenever `rst`=1.
  - `PC_next`=RESET_VEC.
  - Moves to RUN on the first edge with `rst`=0.
- RUN: `PC_next` is chosen by strict priority:
  1. trap → TRAP_VEC; `epc`<=PC_out.
  2. mret → `epc`.
  3. jump → jump_target.
  4. branch_taken → branch_target.
  5. halt_req → PC_out; state<=HALT.
  6. stall → PC_out.
  7. otherwise PC_out+4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
- Misaligned target: a selected jump_target or branch_target with bits [1:0]≠0.
  - That target is not used.
  - `fault`<=1 for one cycle and `epc`<=PC_out.
  - `PC_next`=TRAP_VEC.
- A redirect (trap, mret, jump, branch) overrides stall and halt_req in the same cycle. halt_req is ignored that cycle and must be re-asserted.
- HALT:
  - `PC_next`=PC_out.
  - All redirect inputs are ignored.
  - `resume`=1 → state<=RUN, and that same cycle `PC_next`=PC_out+4.
  - If `halt_req` and `resume` are both 1, `resume` wins.
- Reset mid-operation: any state returns to RST on the next edge. `epc` and `fault` are cleared.

## Timing
- `PC_next` is combinational from the inputs and state, with zero latency. The PC register latches it on the next edge.
- Reset values: state=RST, `epc`=0, `fault`=0. `PC_next`=RESET_VEC for as long as `rst`=1.
- First edge after `rst` falls: state=RUN.
  - PC_out already equals RESET_VEC, latched during reset.
  - On the following edge, PC_out=RESET_VEC+4.
- `fault` and `epc` update on the same edge on which the PC takes TRAP_VEC.
- Entering HALT: the PC holds from the edge after `halt_req` is sampled.

## Configuration
- `PC_CTRL_TRAP_EN` defined: trap, mret, `epc` and the misaligned-fault redirect are implemented as described.
- `PC_CTRL_TRAP_EN` undefined:
  - trap and mret are ignored.
  - `epc` is tied to 0.
  - A misaligned target still pulses `fault`, but the PC holds (`PC_next`=PC_out) and state<=HALT.

## Structure
- `pc_ctrl_pkg` holds:
  - the state enum `pc_state_e` (RST, RUN, HALT);
  - the default constants `PC_RESET_VEC` and `PC_TRAP_VEC`;
  - the constant `PC_INC`=4.
- One sub-module, `pc_next_mux`: a purely combinational priority select. Inputs are the request flags, the targets, PC_out and `epc`. Outputs are `PC_next` plus a one-hot select code used for the state and `epc` updates.
- `pc_ctrl` owns the FSM and the `epc`/`fault` registers.

## Test plan
- Reset: hold `rst` for 2 cycles, then release with no requests → PC_out sequence 0, 4, 8; state=RUN.
- Branch vs. jump: at PC 0x10, assert branch_taken (target 0x40) and jump (target 0x80) together → next PC=0x80. A branch alone to 0x40 → 0x40.
- Misaligned jump_target 0x42 at PC 0x20, with `PC_CTRL_TRAP_EN` → PC=0x100, `epc`=0x20, `fault` high for exactly 1 cycle.
- Trap then mret:
  - trap at PC 0x30 → PC=0x100, `epc`=0x30.
  - mret at PC 0x104 → PC=0x30.
- Halt/stall:
  - halt_req at PC 0x8 → PC holds at 0x8 for 5 cycles; a jump during HALT is ignored.
  - resume → PC=0xC.
  - stall for 3 cycles in RUN → PC constant.
- Wrap and mid-run reset:
  - PC 0xFFFF_FFFC, no request → 0x0.
  - `rst` pulsed while in HALT → state=RST, `epc`=0, then PC=RESET_VEC.
